// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Build option MUL_EARLY_EXIT_EN (see alu_seq_mul_ctrl / alu_sequencer).
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXEC      = 3'd1,
        MUL_ADD   = 3'd2,
        MUL_SHIFT = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam logic [3:0] CMD_SUB  = 4'h0;
    localparam logic [3:0] CMD_ADD  = 4'h1;
    localparam logic [3:0] CMD_LSL  = 4'h2;
    localparam logic [3:0] CMD_NEG  = 4'h3;
    localparam logic [3:0] CMD_PASS = 4'h4;
    localparam logic [3:0] CMD_CMP  = 4'h5;
    localparam logic [3:0] CMD_MUL  = 4'h8;

    localparam logic [2:0] ALU_SUB  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_LSL  = 3'b010;
    localparam logic [2:0] ALU_NEG  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;
    localparam logic [2:0] ALU_CMP  = 3'b101;

    // Direct commands carry their ALU opcode in the low three bits.
    function automatic logic is_direct(input logic [3:0] op);
        return (op <= CMD_CMP);
    endfunction

endpackage

// File: rtl/alu_seq_mul_ctrl.sv
// Multiplier shift register and iteration counter for the shift-add MUL loop.
// With MUL_EARLY_EXIT_EN defined, the loop also ends once no multiplier bits remain.
module alu_seq_mul_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MUL_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_shift,
    output logic             o_bit0,
    output logic             o_done
);

    localparam int CW = $clog2(MUL_BITS + 1);

    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;
    logic             w_last_iter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mplier <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_mplier <= i_b;
            r_count  <= '0;
        end else if (i_shift) begin
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
        end
    end

    assign o_bit0      = r_mplier[0];
    // o_done is evaluated during MUL_SHIFT, before this iteration's increment lands.
    assign w_last_iter = (r_count == CW'(MUL_BITS - 1));

`ifdef MUL_EARLY_EXIT_EN
    assign o_done = w_last_iter || (r_mplier[WIDTH-1:1] == '0);
`else
    assign o_done = w_last_iter;
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Command front end driving an external ALU: single-cycle ops and shift-add MUL.
// Build option MUL_EARLY_EXIT_EN: MUL with b==0 responds at once, loop stops early.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid holds its payload until then.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MUL_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_n,
    output logic             rsp_z,
    output logic             rsp_err,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [2:0]       dbg_state
);

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;      // operand a, and the multiplicand during MUL
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic             w_accept;
    logic             w_bit0;
    logic             w_done;

    assign w_accept = req_valid && (r_state == IDLE);

    alu_seq_mul_ctrl #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_b     (req_b),
        .i_shift (r_state == MUL_SHIFT),
        .o_bit0  (w_bit0),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        alu_op    = ALU_PASS;
        alu_src_a = '0;
        alu_src_b = '0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (is_direct(req_op)) begin
                        w_next = EXEC;
                    end else if (req_op == CMD_MUL) begin
`ifdef MUL_EARLY_EXIT_EN
                        w_next = (req_b == '0) ? RESP : MUL_ADD;
`else
                        w_next = MUL_ADD;
`endif
                    end else begin
                        w_next = RESP;
                    end
                end
            end
            EXEC: begin
                alu_op    = r_op;
                alu_src_a = r_a;
                alu_src_b = r_b;
                w_next    = RESP;
            end
            MUL_ADD: begin
                alu_op    = ALU_ADD;
                alu_src_a = r_acc;
                alu_src_b = w_bit0 ? r_a : '0;
                w_next    = MUL_SHIFT;
            end
            MUL_SHIFT: begin
                alu_op    = ALU_LSL;
                alu_src_a = r_a;
                alu_src_b = WIDTH'(1);
                w_next    = w_done ? RESP : MUL_ADD;
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= ALU_PASS;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op  <= req_op[2:0];
                        r_a   <= req_a;
                        r_b   <= req_b;
                        r_acc <= '0;
                        r_err <= !(is_direct(req_op) || (req_op == CMD_MUL));
                        if (w_next == RESP) r_data <= '0;
                    end
                end
                EXEC:      r_data <= alu_result;
                MUL_ADD:   r_acc  <= alu_result;
                MUL_SHIFT: begin
                    r_a <= alu_result;
                    if (w_done) r_data <= r_acc;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_data;
    assign rsp_n     = r_data[WIDTH-1];
    assign rsp_z     = (r_data == '0);
    assign rsp_err   = r_err;
    assign dbg_state = r_state;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle command front end that drives the datapath ALU's `ALUop`/`srcA`/`srcB` inputs and collects `ALUresult`. It accepts operation requests over a valid/ready handshake. Single ALU operations are issued in one cycle. A 16×16→16 multiply is built from repeated ALU add and left-shift operations. Results and N/Z flags are returned over a second valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; must equal ALU width.
- `MUL_BITS`, 16, multiplier bits iterated by MUL.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; equals (state==IDLE).
- `req_op`  in  4  command code.
- `req_a`, `req_b`  in  WIDTH  operands.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  WIDTH  result.
- `rsp_n`, `rsp_z`  out  1  `rsp_data[WIDTH-1]`, (`rsp_data`==0).
- `rsp_err`  out  1  unsupported `req_op`.
- `alu_op`  out  3  to ALU `ALUop`.
- `alu_src_a`, `alu_src_b`  out  WIDTH  to ALU `srcA`, `srcB`.
- `alu_result`  in  WIDTH  from ALU `ALUresult`.

## Operation
- Command codes:
  - 0x0 SUB, 0x1 ADD, 0x2 LSL, 0x3 NEG, 0x4 PASS, 0x5 CMP map directly to `alu_op` = `req_op[2:0]`.
  - 0x8 MUL.
  - All other codes are invalid.
- States: IDLE, EXEC, MUL_ADD, MUL_SHIFT, RESP.
- IDLE: on `req_valid`&&`req_ready`, latch op, a, b.
  - Direct op → EXEC.
  - MUL → MUL_ADD. Exception: when `MUL_EARLY_EXIT_EN` is defined and b==0, go to RESP with data 0.
  - Invalid → RESP with data 0 and `rsp_err`=1.
- EXEC: drive `alu_op`=op, srcA=a, srcB=b; capture `alu_result` → RESP.
- MUL (acc=0, mcand=a, mplier=b at accept):
  - MUL_ADD: `alu_op`=001, srcA=acc, srcB=(mplier[0] ? mcand : 0); acc←`alu_result` → MUL_SHIFT.
  - MUL_SHIFT: `alu_op`=010, srcA=mcand, srcB=1; mcand←`alu_result`; mplier←mplier>>1; count+1. Exit to RESP when count==MUL_BITS, or per the Configuration section; otherwise → MUL_ADD.
- All arithmetic is modulo 2^WIDTH; the upper product bits are discarded; there is no overflow flag.
- RESP: `rsp_valid`=1 with data, flags and err stable until `rsp_ready`; on the handshake → IDLE.
- When the ALU is unused (IDLE/RESP): `alu_op`=100, srcA=srcB=0.
- No new request is accepted while busy; `req_ready`=0 outside IDLE.

## Timing
- Reset (async assert, clk-synchronous release):
  - State is IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0; hence `rsp_n`=0 and `rsp_z`=1.
  - `alu_op`=100, srcs=0, internal acc/count cleared.
- Reset mid-MUL or mid-RESP aborts immediately; the pending response is lost.
- With the accept edge at T, `rsp_valid` rises at:
  - Direct op: T+2.
  - Invalid: T+1.
  - MUL, fixed: T+1+2·MUL_BITS (T+33).
- No same-cycle turnaround: after the RESP handshake edge, `req_ready` is 1 in the next cycle, and the earliest new accept is that edge.
- `rsp_valid` held with `rsp_ready`=0 for any number of cycles: outputs do not change.
- `req_valid` asserted while busy is ignored, not queued.

## Configuration
- `MUL_EARLY_EXIT_EN`:
  - Defined: MUL_SHIFT exits to RESP when the shifted mplier==0; a b==0 MUL goes IDLE→RESP directly (`rsp_valid` at T+1). Latency = T+1+2·(index of highest set bit of b + 1).
  - Undefined: always MUL_BITS iterations; latency is constant T+33.
- Result values are identical either way.

## Structure
- Package `alu_seq_pkg`:
  - state enum;
  - command-code constants;
  - ALU op constants (SUB=000, ADD=001, LSL=010, NEG=011, PASS=100, CMP=101).
- One sub-module, `alu_seq_mul_ctrl`: mplier shift register, iteration counter, done/early-exit detect. FSM and acc/mcand registers stay in `alu_sequencer`.
- The ALU is instantiated at the parent level, not inside this block.

## Test plan
- Reset, then ADD a=0x0003 b=0x0004 → `rsp_valid` at T+2, data 0x0007, n=0, z=0, err=0; `alu_op` seen as 001 in EXEC.
- SUB a=0x0002 b=0x0005 → data 0xFFFD, n=1; CMP a=b=0x1234 → data 0, z=1.
- MUL a=0x0012 b=0x0034 → data 0x03A8; `rsp_valid` at T+33 without the macro, T+13 with it. Also MUL 0x0100×0x0100 → 0x0000, z=1.
- MUL b=0x0000 with macro → `rsp_valid` at T+1, data 0; op 0xF → `rsp_valid` at T+1, err=1, data 0.
- Hold `rsp_ready`=0 for 5 cycles with `req_valid`=1 → response stable, `req_ready`=0, no second accept; release → next request accepted one cycle after the handshake.
- Assert `rst_n`=0 at iteration 7 of a MUL → same cycle: `rsp_valid`=0, `req_ready`=1, `alu_op`=100; after release an ADD completes normally.
